// File: rtl/out_channel_checker.sv
// out_channel_checker
//   Consumer end of the executor's output channel. Expected words are
//   preloaded into a small buffer. After start, every output word accepted
//   from the executor is compared in order against that buffer. The block
//   then raises finished/success for the test harness.
//
// Ports
//   clock, reset           : clock; asynchronous active-low reset
//   expect_valid/_data/_ready : preload handshake (IDLE only)
//   start, clear           : single-cycle control pulses
//   out_valid/_data/_ready : executor output-word handshake
//   finished, success      : verdict (success meaningful when finished=1)
//   mismatch_index         : position of the first failure
//   received_count         : output words accepted, saturating at all-ones
module out_channel_checker #(
  parameter int MemoryElementWidth = 12,
  parameter int NOut               = 8,
  parameter int IndexWidth         = 4,
  parameter int TimeoutCycles      = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          expect_valid,
  input  logic [MemoryElementWidth-1:0] expect_data,
  output logic                          expect_ready,
  input  logic                          start,
  input  logic                          clear,
  input  logic                          out_valid,
  input  logic [MemoryElementWidth-1:0] out_data,
  output logic                          out_ready,
  output logic                          finished,
  output logic                          success,
  output logic [IndexWidth-1:0]         mismatch_index,
  output logic [IndexWidth-1:0]         received_count
);

  localparam int TimerWidth = $clog2(TimeoutCycles + 1);
  localparam logic [IndexWidth-1:0] NOutIdx   = IndexWidth'(NOut);
  localparam logic [IndexWidth-1:0] IdxOne    = IndexWidth'(1);
  localparam logic [TimerWidth-1:0] TimerOne  = TimerWidth'(1);
  localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TimeoutCycles - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [IndexWidth-1:0]   loaded_q, loaded_d;
  logic [IndexWidth-1:0]   pos_q, pos_d;
  logic [IndexWidth-1:0]   rcv_q, rcv_d;
  logic [IndexWidth-1:0]   mis_q, mis_d;
  logic [TimerWidth-1:0]   timer_q, timer_d;
  logic                    success_q, success_d;

  logic [MemoryElementWidth-1:0] buffer_q [NOut];
  logic [MemoryElementWidth-1:0] exp_word;
  logic                          buf_we;
  logic                          expect_fire;
  logic                          out_fire;
  logic [IndexWidth-1:0]         rcv_inc;

  // Readies depend only on registered state, never on the valids.
  assign expect_ready   = (state_q == ST_IDLE) && (loaded_q < NOutIdx);
  assign out_ready      = (state_q != ST_IDLE);
  assign expect_fire    = expect_valid && expect_ready;
  assign out_fire       = out_valid && out_ready;
  assign finished       = (state_q == ST_DONE);
  assign success        = success_q;
  assign mismatch_index = mis_q;
  assign received_count = rcv_q;

  assign rcv_inc = (rcv_q == '1) ? rcv_q : rcv_q + IdxOne;

  // A clear in the same cycle discards the offered expected word.
  assign buf_we = expect_fire && !clear;

  always_comb begin
    exp_word = '0;
    for (int i = 0; i < NOut; i++) begin
      if (pos_q == IndexWidth'(i)) exp_word = buffer_q[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    loaded_d  = loaded_q;
    pos_d     = pos_q;
    rcv_d     = rcv_q;
    mis_d     = mis_q;
    timer_d   = timer_q;
    success_d = success_q;

    if (clear) begin
      state_d   = ST_IDLE;
      loaded_d  = '0;
      pos_d     = '0;
      rcv_d     = '0;
      mis_d     = '0;
      timer_d   = '0;
      success_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (expect_fire) loaded_d = loaded_q + IdxOne;
          // Decide on the post-load count so a same-cycle word is included.
          if (start) begin
            if (loaded_d == '0) begin
              state_d   = ST_DONE;
              success_d = 1'b1;
            end else begin
              state_d = ST_RUN;
              pos_d   = '0;
              timer_d = '0;
            end
          end
        end
        ST_RUN: begin
          if (out_fire) begin
            rcv_d   = rcv_inc;
            timer_d = '0;
            if (out_data != exp_word) begin
              state_d   = ST_DONE;
              success_d = 1'b0;
              mis_d     = pos_q;
            end else if (pos_q == loaded_q - IdxOne) begin
              state_d   = ST_DONE;
              success_d = 1'b1;
            end else begin
              pos_d = pos_q + IdxOne;
            end
          end else if (timer_q == TimerLast) begin
            state_d   = ST_DONE;
            success_d = 1'b0;
            mis_d     = pos_q;
          end else begin
            timer_d = timer_q + TimerOne;
          end
        end
        ST_DONE: begin
          // Overrun: only the first extra word after a pass records an index.
          if (out_fire) begin
            rcv_d = rcv_inc;
            if (success_q) begin
              success_d = 1'b0;
              mis_d     = loaded_q;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      loaded_q  <= '0;
      pos_q     <= '0;
      rcv_q     <= '0;
      mis_q     <= '0;
      timer_q   <= '0;
      success_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      loaded_q  <= loaded_d;
      pos_q     <= pos_d;
      rcv_q     <= rcv_d;
      mis_q     <= mis_d;
      timer_q   <= timer_d;
      success_q <= success_d;
    end
  end

  // Buffer data carries no reset; loaded_q alone says which entries are live.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NOut; i++) begin
      if (buf_we && (loaded_q == IndexWidth'(i))) buffer_q[i] <= expect_data;
    end
  end

endmodule

// File: tb/tb_out_channel_checker.sv
`timescale 1ns/1ps
module tb_out_channel_checker;

  localparam int W    = 12;
  localparam int NOUT = 8;
  localparam int IW   = 4;
  localparam int TO   = 64;

  logic          clock = 1'b0;
  logic          reset;
  logic          expect_valid;
  logic [W-1:0]  expect_data;
  logic          expect_ready;
  logic          start;
  logic          clear;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic          finished;
  logic          success;
  logic [IW-1:0] mismatch_index;
  logic [IW-1:0] received_count;

  always #5 clock = ~clock;

  out_channel_checker #(
    .MemoryElementWidth(W),
    .NOut(NOUT),
    .IndexWidth(IW),
    .TimeoutCycles(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .expect_valid(expect_valid),
    .expect_data(expect_data),
    .expect_ready(expect_ready),
    .start(start),
    .clear(clear),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .finished(finished),
    .success(success),
    .mismatch_index(mismatch_index),
    .received_count(received_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the expected list is a queue; the run is described by
  // three phases (loading, checking, verdict) and plain integer counters.
  localparam int PH_LOAD = 0;
  localparam int PH_CHK  = 1;
  localparam int PH_DONE = 2;

  int           m_phase;
  logic [W-1:0] m_words[$];
  int           m_pos;
  int           m_idle;
  int           m_rcv;
  int           m_mis;
  bit           m_succ;

  function automatic void model_reset();
    m_phase = PH_LOAD;
    m_words.delete();
    m_pos  = 0;
    m_idle = 0;
    m_rcv  = 0;
    m_mis  = 0;
    m_succ = 1'b0;
  endfunction

  function automatic void model_count();
    if (m_rcv < (1 << IW) - 1) m_rcv++;
  endfunction

  function automatic void model_step();
    if (clear) begin
      model_reset();
      return;
    end
    case (m_phase)
      PH_LOAD: begin
        if (expect_valid && m_words.size() < NOUT) m_words.push_back(expect_data);
        if (start) begin
          if (m_words.size() == 0) begin
            m_phase = PH_DONE;
            m_succ  = 1'b1;
          end else begin
            m_phase = PH_CHK;
            m_pos   = 0;
            m_idle  = 0;
          end
        end
      end
      PH_CHK: begin
        if (out_valid) begin
          model_count();
          m_idle = 0;
          if (out_data != m_words[m_pos]) begin
            m_phase = PH_DONE;
            m_succ  = 1'b0;
            m_mis   = m_pos;
          end else if (m_pos == m_words.size() - 1) begin
            m_phase = PH_DONE;
            m_succ  = 1'b1;
          end else begin
            m_pos++;
          end
        end else begin
          m_idle++;
          if (m_idle == TO) begin
            m_phase = PH_DONE;
            m_succ  = 1'b0;
            m_mis   = m_pos;
          end
        end
      end
      default: begin
        if (out_valid) begin
          model_count();
          if (m_succ) begin
            m_succ = 1'b0;
            m_mis  = m_words.size();
          end
        end
      end
    endcase
  endfunction

  task automatic compare_all();
    check_eq("finished",       32'(finished),       32'(m_phase == PH_DONE));
    check_eq("success",        32'(success),        32'(m_succ));
    check_eq("mismatch_index", 32'(mismatch_index), 32'(m_mis));
    check_eq("received_count", 32'(received_count), 32'(m_rcv));
    check_eq("out_ready",      32'(out_ready),      32'(m_phase != PH_LOAD));
    check_eq("expect_ready",   32'(expect_ready),
             32'((m_phase == PH_LOAD) && (m_words.size() < NOUT)));
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_finished"},  32'(finished),       32'd0);
    check_eq({tag, "_success"},   32'(success),        32'd0);
    check_eq({tag, "_mis"},       32'(mismatch_index), 32'd0);
    check_eq({tag, "_rcv"},       32'(received_count), 32'd0);
    check_eq({tag, "_out_rdy"},   32'(out_ready),      32'd0);
    check_eq({tag, "_exp_rdy"},   32'(expect_ready),   32'd1);
  endtask

  // One clock: compare on the falling edge, advance the model, leave the
  // bench 1 ns after the rising edge ready for new inputs.
  task automatic tick();
    @(negedge clock);
    compare_all();
    if (!reset) model_reset();
    else        model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic load(input int w);
    expect_valid = 1'b1; expect_data = W'(w); tick(); expect_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send(input int w);
    out_valid = 1'b1; out_data = W'(w); tick(); out_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; expect_valid = 1'b0; expect_data = '0; start = 1'b0;
    clear = 1'b0; out_valid = 1'b0; out_data = '0;
    model_reset();
    #12;
    check_reset_values("por");
    idle(2);
    reset = 1'b1;
    idle(1);

    // Two words returned back-to-back.
    do_clear(); load(111); load(333); pulse_start();
    send(111);
    check_eq("tp1_fin_early", 32'(finished), 32'd0);
    send(333);
    check_eq("tp1_fin", 32'(finished), 32'd1);
    check_eq("tp1_succ", 32'(success), 32'd1);
    check_eq("tp1_rcv", 32'(received_count), 32'd2);

    // Mismatch at the second word, then an overrun leaves the index frozen.
    do_clear(); load(111); load(333); pulse_start();
    send(111); send(222);
    check_eq("tp2_fin", 32'(finished), 32'd1);
    check_eq("tp2_succ", 32'(success), 32'd0);
    check_eq("tp2_mis", 32'(mismatch_index), 32'd1);
    send(444);
    check_eq("tp2_mis_frozen", 32'(mismatch_index), 32'd1);
    check_eq("tp2_rcv", 32'(received_count), 32'd3);

    // Timeout after one word.
    do_clear(); load(111); load(333); pulse_start();
    send(111); idle(TO - 1);
    check_eq("tp3_fin_early", 32'(finished), 32'd0);
    idle(1);
    check_eq("tp3_fin", 32'(finished), 32'd1);
    check_eq("tp3_succ", 32'(success), 32'd0);
    check_eq("tp3_mis", 32'(mismatch_index), 32'd1);
    check_eq("tp3_rcv", 32'(received_count), 32'd1);

    // Pass followed by an overrun word.
    do_clear(); load(111); pulse_start(); send(111);
    check_eq("tp4_succ_pre", 32'(success), 32'd1);
    send(5);
    check_eq("tp4_succ", 32'(success), 32'd0);
    check_eq("tp4_mis", 32'(mismatch_index), 32'd1);
    check_eq("tp4_rcv", 32'(received_count), 32'd2);
    check_eq("tp4_fin", 32'(finished), 32'd1);

    // Full buffer, ignored ninth word, then every word returned.
    do_clear();
    for (int i = 0; i < NOUT; i++) load(i * 10 + 1);
    check_eq("tp5_exp_rdy_full", 32'(expect_ready), 32'd0);
    load(999);
    pulse_start();
    for (int i = 0; i < NOUT; i++) send(i * 10 + 1);
    check_eq("tp5_succ", 32'(success), 32'd1);
    check_eq("tp5_rcv", 32'(received_count), 32'd8);
    do_clear(); pulse_start();
    check_eq("tp5_empty_fin", 32'(finished), 32'd1);
    check_eq("tp5_empty_succ", 32'(success), 32'd1);

    // Word offered in the same cycle as start is part of the run.
    do_clear();
    expect_valid = 1'b1; expect_data = W'(42); start = 1'b1; tick();
    expect_valid = 1'b0; start = 1'b0;
    send(42);
    check_eq("same_cycle_succ", 32'(success), 32'd1);

    // Asynchronous reset in the middle of a run.
    do_clear(); load(7); load(8); pulse_start(); send(7);
    #2 reset = 1'b0;
    #1 check_reset_values("async_rst");
    model_reset();
    idle(2);
    reset = 1'b1;
    load(7); pulse_start(); send(7);
    check_eq("tp6_succ", 32'(success), 32'd1);
    check_eq("tp6_fin", 32'(finished), 32'd1);
    do_clear();
    check_eq("tp6_clr_fin", 32'(finished), 32'd0);
    check_eq("tp6_clr_exp_rdy", 32'(expect_ready), 32'd1);

    // Randomized runs against the model.
    for (int it = 0; it < 300; it++) begin
      int n;
      do_clear();
      n = $urandom_range(0, 9);
      for (int k = 0; k < n; k++) begin
        expect_valid = ($urandom_range(0, 3) != 0);
        expect_data  = W'($urandom_range(0, 4095));
        start        = (k == n - 1) && ($urandom_range(0, 1) == 1);
        tick();
      end
      expect_valid = 1'b0;
      pulse_start();
      for (int c = 0; c < int'($urandom_range(5, 40)); c++) begin
        out_valid = ($urandom_range(0, 2) != 0);
        if (m_phase == PH_CHK && $urandom_range(0, 7) != 0) out_data = m_words[m_pos];
        else out_data = W'($urandom_range(0, 4095));
        start        = ($urandom_range(0, 15) == 0);
        expect_valid = ($urandom_range(0, 3) == 0);
        expect_data  = W'($urandom_range(0, 4095));
        clear        = ($urandom_range(0, 63) == 0);
        tick();
      end
      out_valid = 1'b0; start = 1'b0; expect_valid = 1'b0; clear = 1'b0;
      if (it % 10 == 0) idle(TO + 6);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
